flex_down_timer: RTL and testbench
==================================

Name: flex_down_timer

Overview:
Programmable down-counting interval timer with a start/stop handshake, prescaler, and one-shot or periodic modes. It counts down from a loaded value and raises a registered single-cycle expire pulse. It is the countdown counterpart to the team's up-counting flex counter, and is used for timeouts and bit-period timing in the protocol blocks.

Parameters:
NUM_CNT_BITS, 8, width of the countdown value and count_out.
PRESCALE_BITS, 4, width of the prescale divider value.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
n_rst  input  1  asynchronous active-low reset.
start  input  1  1-cycle request: load load_val and begin counting.
stop  input  1  abort: return to IDLE, no expire pulse.
periodic  input  1  sampled on start; 1 = auto-reload, 0 = one-shot.
load_val  input  NUM_CNT_BITS  countdown start value; sampled on accepted start.
prescale_val  input  PRESCALE_BITS  tick every prescale_val+1 clocks; sampled on start.
count_out  output  NUM_CNT_BITS  current remaining count.
busy  output  1  high in RUN.
expire_flag  output  1  registered 1-cycle pulse on each expiry.
done  output  1  level; high after one-shot expiry until next start or stop.

Behaviour:
- Reset is asynchronous, active-low (n_rst), on clock clk. Reset values: count_out=0, busy=0, expire_flag=0, done=0, state=IDLE, prescale counter=0, reload and mode registers=0.
- FSM states: IDLE, RUN, DONE.
- Priority: reset > stop > start > tick.
- stop in any state:
  - next state IDLE, count_out=0, done=0, busy=0.
  - expire_flag=0 the next cycle, even if a tick coincides.
- Accepted start (any state, including RUN, which restarts):
  - latch load_val into the reload register; latch periodic and prescale_val.
  - count_out=load_val, prescale counter=0, done=0.
  - next state RUN, except load_val==0: state DONE, done=1, expire_flag pulses the next cycle; periodic is ignored for a zero load.
- Tick generation:
  - prescale counter increments in RUN.
  - tick fires when counter==latched prescale_val, then the counter wraps to 0.
  - prescale_val=0 gives a tick every cycle.
  - The first tick occurs latched_prescale+1 cycles after the start edge.
- In RUN, on a tick:
  - count_out>1: decrement by 1.
  - count_out==1 and one-shot: count_out=0, state DONE, done=1, busy=0, expire_flag=1 for one cycle.
  - count_out==1 and periodic: count_out=reload value, stay RUN, expire_flag=1 for one cycle.
- Latency example (prescale 0, load N): start seen at edge E; expire_flag is high during the cycle following edge E+N; period in periodic mode is N*(prescale+1) cycles.
- busy is combinational from the state register (state==RUN); done and expire_flag are registered.
- No arithmetic wrap: count_out never decrements below 0.
- Inputs other than start/stop are ignored outside the start cycle.

Optional Feature:
FLEX_TIMER_PAUSE_EN.
- Defined: adds input port pause (1 bit). While pause=1 in RUN:
  - prescale counter and count_out hold; no ticks are generated.
  - busy stays 1.
  - stop and start still take effect.
- Undefined: port absent; the timer never holds.

Decomposition:
- Package flex_timer_pkg: state enum typedef (IDLE, RUN, DONE) and the localparam state encoding width.
- Sub-module flex_tick_gen: prescale counter with PRESCALE_BITS parameter, inputs enable/clear/div_val, output tick.
- The FSM and countdown stay in flex_down_timer.

Test Plan:
- Reset mid-RUN (load 5, prescale 0, deassert n_rst at count 3) -> all outputs 0 immediately; state IDLE.
- One-shot (load 4, prescale 0) -> count_out 4,3,2,1,0; expire_flag high exactly 1 cycle, 4 cycles after load; done=1 held; busy=0.
- Periodic (load 3, prescale 2) -> expire_flag every 9 cycles; count_out reloads 1->3, never shows 0; runs until stop.
- stop on the cycle count_out==1 with a tick due -> no expire_flag; count_out=0; done=0; IDLE.
- start with load_val=0 -> expire_flag 1 cycle later; done=1; busy never asserted. Restart during RUN with load 7 -> count_out=7 next cycle; prescaler restarts.
- (FLEX_TIMER_PAUSE_EN) load 6, prescale 0, pause 3 cycles at count 4 -> count_out holds 4; expiry delayed exactly 3 cycles.

Source files
------------

// File: rtl/flex_timer_pkg.sv
// -----------------------------------------------------------------------------
// flex_timer_pkg
// Shared types for the flex_down_timer block: the controller state encoding
// and a small helper used to decode the running state.
// Optional feature macro used by the timer: FLEX_TIMER_PAUSE_EN.
// -----------------------------------------------------------------------------
package flex_timer_pkg;

  localparam int STATE_BITS = 2;

  typedef enum logic [STATE_BITS-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // True while the timer is actively counting down.
  function automatic logic is_running(input state_t st);
    return (st == RUN);
  endfunction

endpackage

// File: rtl/flex_tick_gen.sv
// -----------------------------------------------------------------------------
// flex_tick_gen
// Prescale divider for flex_down_timer. Produces a tick once every
// div_val+1 enabled clocks, starting from a cleared counter.
// Ports:
//   clk     - system clock
//   n_rst   - asynchronous active-low reset
//   enable  - advance the prescale counter this cycle
//   clear   - force the counter back to 0 (wins over enable)
//   div_val - terminal count; tick when counter equals it
//   tick    - high for the cycle in which the counter hits div_val
// -----------------------------------------------------------------------------
module flex_tick_gen #(
  parameter int PRESCALE_BITS = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     enable,
  input  logic                     clear,
  input  logic [PRESCALE_BITS-1:0] div_val,
  output logic                     tick
);

  logic [PRESCALE_BITS-1:0] cnt_r;
  logic [PRESCALE_BITS-1:0] cnt_nxt_s;
  logic                     hit_s;

  assign hit_s = (cnt_r == div_val);
  // A clear (start/stop) always beats a coincident tick.
  assign tick  = enable && !clear && hit_s;

  // Next prescale count: clear, wrap on terminal count, or hold when disabled.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (clear) begin
      cnt_nxt_s = {PRESCALE_BITS{1'b0}};
    end else if (enable) begin
      if (hit_s) begin
        cnt_nxt_s = {PRESCALE_BITS{1'b0}};
      end else begin
        cnt_nxt_s = cnt_r + PRESCALE_BITS'(1);
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Prescale counter register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_r <= {PRESCALE_BITS{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

endmodule

// File: rtl/flex_down_timer.sv
// -----------------------------------------------------------------------------
// flex_down_timer
// Programmable down-counting interval timer with prescaler, one-shot and
// periodic modes. Loads load_val on start, decrements once per prescaled
// tick, and raises a registered single-cycle expire_flag on each expiry.
// Optional feature: define FLEX_TIMER_PAUSE_EN to add a pause input that
// freezes the count and prescaler while running.
// Ports:
//   clk          - system clock, rising edge
//   n_rst        - asynchronous active-low reset
//   pause        - (FLEX_TIMER_PAUSE_EN only) hold count/prescaler in RUN
//   start        - load load_val and begin counting (restarts if running)
//   stop         - abort to IDLE, suppresses any expiry
//   periodic     - 1 = auto-reload, 0 = one-shot; sampled on start
//   load_val     - countdown start value; sampled on start
//   prescale_val - tick every prescale_val+1 clocks; sampled on start
//   count_out    - remaining count
//   busy         - high while in RUN
//   expire_flag  - one-cycle pulse per expiry
//   done         - level, high after one-shot expiry until start/stop
// -----------------------------------------------------------------------------
module flex_down_timer
  import flex_timer_pkg::*;
#(
  parameter int NUM_CNT_BITS  = 8,
  parameter int PRESCALE_BITS = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
`ifdef FLEX_TIMER_PAUSE_EN
  input  logic                     pause,
`endif
  input  logic                     start,
  input  logic                     stop,
  input  logic                     periodic,
  input  logic [NUM_CNT_BITS-1:0]  load_val,
  input  logic [PRESCALE_BITS-1:0] prescale_val,
  output logic [NUM_CNT_BITS-1:0]  count_out,
  output logic                     busy,
  output logic                     expire_flag,
  output logic                     done
);

  localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = {NUM_CNT_BITS{1'b0}};
  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = NUM_CNT_BITS'(1);

  state_t                     state_r;
  state_t                     state_nxt_s;
  logic [NUM_CNT_BITS-1:0]    count_r;
  logic [NUM_CNT_BITS-1:0]    count_nxt_s;
  logic [NUM_CNT_BITS-1:0]    reload_r;
  logic [NUM_CNT_BITS-1:0]    reload_nxt_s;
  logic                       periodic_r;
  logic                       periodic_nxt_s;
  logic [PRESCALE_BITS-1:0]   prescale_r;
  logic [PRESCALE_BITS-1:0]   prescale_nxt_s;
  logic                       done_r;
  logic                       done_nxt_s;
  logic                       expire_r;
  logic                       expire_nxt_s;
  logic                       pause_s;
  logic                       tick_en_s;
  logic                       tick_s;

`ifdef FLEX_TIMER_PAUSE_EN
  assign pause_s = pause;
`else
  assign pause_s = 1'b0;
`endif

  assign tick_en_s = is_running(state_r) && !pause_s;

  flex_tick_gen #(
    .PRESCALE_BITS (PRESCALE_BITS)
  ) u_tick_gen (
    .clk     (clk),
    .n_rst   (n_rst),
    .enable  (tick_en_s),
    .clear   (start || stop),
    .div_val (prescale_r),
    .tick    (tick_s)
  );

  // Next-state and countdown logic; priority stop > start > tick.
  always_comb begin
    state_nxt_s    = state_r;
    count_nxt_s    = count_r;
    reload_nxt_s   = reload_r;
    periodic_nxt_s = periodic_r;
    prescale_nxt_s = prescale_r;
    done_nxt_s     = done_r;
    expire_nxt_s   = 1'b0;

    if (stop) begin
      state_nxt_s = IDLE;
      count_nxt_s = CNT_ZERO;
      done_nxt_s  = 1'b0;
    end else if (start) begin
      reload_nxt_s   = load_val;
      periodic_nxt_s = periodic;
      prescale_nxt_s = prescale_val;
      count_nxt_s    = load_val;
      if (load_val == CNT_ZERO) begin
        // Zero load expires immediately regardless of mode.
        state_nxt_s  = DONE;
        done_nxt_s   = 1'b1;
        expire_nxt_s = 1'b1;
      end else begin
        state_nxt_s = RUN;
        done_nxt_s  = 1'b0;
      end
    end else begin
      case (state_r)
        RUN: begin
          if (tick_s) begin
            if (count_r > CNT_ONE) begin
              count_nxt_s = count_r - CNT_ONE;
            end else if (count_r == CNT_ONE) begin
              expire_nxt_s = 1'b1;
              if (periodic_r) begin
                count_nxt_s = reload_r;
              end else begin
                count_nxt_s = CNT_ZERO;
                state_nxt_s = DONE;
                done_nxt_s  = 1'b1;
              end
            end else begin
              // Count already zero: never wrap below it.
              count_nxt_s = CNT_ZERO;
            end
          end else begin
            count_nxt_s = count_r;
          end
        end
        IDLE: begin
          state_nxt_s = IDLE;
        end
        DONE: begin
          state_nxt_s = DONE;
        end
        default: begin
          state_nxt_s = IDLE;
          count_nxt_s = CNT_ZERO;
          done_nxt_s  = 1'b0;
        end
      endcase
    end
  end

  // State, countdown and latched configuration registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r    <= IDLE;
      count_r    <= CNT_ZERO;
      reload_r   <= CNT_ZERO;
      periodic_r <= 1'b0;
      prescale_r <= {PRESCALE_BITS{1'b0}};
      done_r     <= 1'b0;
      expire_r   <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      count_r    <= count_nxt_s;
      reload_r   <= reload_nxt_s;
      periodic_r <= periodic_nxt_s;
      prescale_r <= prescale_nxt_s;
      done_r     <= done_nxt_s;
      expire_r   <= expire_nxt_s;
    end
  end

  assign count_out   = count_r;
  assign busy        = is_running(state_r);
  assign done        = done_r;
  assign expire_flag = expire_r;

endmodule

// File: tb/tb_flex_down_timer.sv
// -----------------------------------------------------------------------------
// tb_flex_down_timer
// Directed bench for flex_down_timer. A cycle-level model derives expected
// outputs from the number of active cycles since the last start:
// ticks = active/(prescale+1), remaining = load - ticks (modulo load when
// periodic). Every cycle the DUT is compared to it, and a few hand-computed
// literals pin the model.
// -----------------------------------------------------------------------------
module tb_flex_down_timer;

  logic       clk;
  logic       n_rst;
  logic       start;
  logic       stop;
  logic       periodic;
  logic [7:0] load_val;
  logic [3:0] prescale_val;
  logic       pause;
  logic [7:0] count_out;
  logic       busy;
  logic       expire_flag;
  logic       done;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  // model state
  bit m_run;
  bit m_done;
  bit m_expire;
  int m_count;
  int m_n;
  int m_p;
  bit m_per;
  int m_e;

  flex_down_timer dut (
    .clk          (clk),
    .n_rst        (n_rst),
`ifdef FLEX_TIMER_PAUSE_EN
    .pause        (pause),
`endif
    .start        (start),
    .stop         (stop),
    .periodic     (periodic),
    .load_val     (load_val),
    .prescale_val (prescale_val),
    .count_out    (count_out),
    .busy         (busy),
    .expire_flag  (expire_flag),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance the model by one clock edge using the inputs held during the cycle.
  task automatic model_edge();
    int ticks;
    int rem;
    bit paused;
`ifdef FLEX_TIMER_PAUSE_EN
    paused = pause;
`else
    paused = 1'b0;
`endif
    if (!n_rst) begin
      m_run = 0; m_done = 0; m_expire = 0; m_count = 0;
      m_n = 0; m_p = 0; m_per = 0; m_e = 0;
    end else begin
      m_expire = 0;
      if (stop) begin
        m_run = 0; m_done = 0; m_count = 0;
      end else if (start) begin
        m_n = int'(load_val); m_p = int'(prescale_val); m_per = periodic; m_e = 0;
        m_count = m_n;
        if (m_n == 0) begin
          m_run = 0; m_done = 1; m_expire = 1;
        end else begin
          m_run = 1; m_done = 0;
        end
      end else if (m_run && !paused) begin
        m_e++;
        ticks = m_e / (m_p + 1);
        if (m_per) begin
          rem = ticks % m_n;
          m_count = (rem == 0) ? m_n : m_n - rem;
          m_expire = (m_e % (m_p + 1) == 0) && (rem == 0);
        end else if (ticks >= m_n) begin
          m_run = 0; m_done = 1; m_count = 0; m_expire = 1;
        end else begin
          m_count = m_n - ticks;
        end
      end
    end
  endtask

  // One clock: update model at the edge, compare just after, return at negedge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check("count_out", int'(count_out), m_count);
    check("busy", int'(busy), int'(m_run));
    check("done", int'(done), int'(m_done));
    check("expire_flag", int'(expire_flag), int'(m_expire));
    @(negedge clk);
  endtask

  task automatic do_start(input int n, input int p, input bit per);
    start = 1'b1; load_val = 8'(n); prescale_val = 4'(p); periodic = per;
    step();
    start = 1'b0; load_val = 8'd0; prescale_val = 4'd0; periodic = 1'b0;
  endtask

  initial begin
    int last_exp;
    int exp_cnt;
    n_rst = 1'b0; start = 1'b0; stop = 1'b0; periodic = 1'b0;
    load_val = 8'd0; prescale_val = 4'd0; pause = 1'b0;
    step();
    step();
    check("rst_count", int'(count_out), 0);
    check("rst_busy", int'(busy), 0);
    n_rst = 1'b1;
    step();

    // Reset mid-RUN at count 3
    do_start(5, 0, 1'b0);
    step();
    step();
    check("pre_rst_count", int'(count_out), 3);
    n_rst = 1'b0;
    #1;
    check("async_rst_count", int'(count_out), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_done", int'(done), 0);
    check("async_rst_exp", int'(expire_flag), 0);
    @(negedge clk);
    step();
    n_rst = 1'b1;
    step();

    // One-shot load 4, prescale 0: 4,3,2,1,0 with expiry on the 4th edge
    do_start(4, 0, 1'b0);
    check("os_load", int'(count_out), 4);
    for (int i = 0; i < 3; i++) step();
    check("os_one", int'(count_out), 1);
    check("os_no_exp_yet", int'(expire_flag), 0);
    step();
    check("os_exp", int'(expire_flag), 1);
    check("os_done", int'(done), 1);
    check("os_zero", int'(count_out), 0);
    step();
    check("os_exp_single", int'(expire_flag), 0);
    check("os_done_held", int'(done), 1);
    step();

    // Periodic load 3, prescale 2: expiry every 9 cycles, count never 0
    do_start(3, 2, 1'b1);
    last_exp = -1;
    exp_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      check("per_nonzero", int'(count_out != 8'd0), 1);
      if (expire_flag) begin
        if (last_exp >= 0) check("per_period", cyc - last_exp, 9);
        last_exp = cyc;
        exp_cnt++;
      end
    end
    check("per_exp_count", exp_cnt, 3);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("per_stop_busy", int'(busy), 0);
    step();

    // stop while count==1 and a tick is due
    do_start(2, 0, 1'b0);
    step();
    check("stop_pre", int'(count_out), 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_exp", int'(expire_flag), 0);
    check("stop_count", int'(count_out), 0);
    check("stop_done", int'(done), 0);
    step();

    // zero load
    do_start(0, 3, 1'b1);
    check("zero_exp", int'(expire_flag), 1);
    check("zero_done", int'(done), 1);
    check("zero_busy", int'(busy), 0);
    step();
    check("zero_exp_single", int'(expire_flag), 0);

    // restart during RUN, prescaler restarts
    do_start(5, 1, 1'b0);
    step();
    step();
    step();
    do_start(7, 1, 1'b0);
    check("restart_load", int'(count_out), 7);
    step();
    check("restart_hold", int'(count_out), 7);
    step();
    check("restart_dec", int'(count_out), 6);
    for (int i = 0; i < 14; i++) step();

`ifdef FLEX_TIMER_PAUSE_EN
    // pause 3 cycles at count 4: expiry 9 edges after start
    do_start(6, 0, 1'b0);
    step();
    step();
    check("pause_at", int'(count_out), 4);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("pause_hold", int'(count_out), 4);
      check("pause_busy", int'(busy), 1);
    end
    pause = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("pause_no_exp", int'(expire_flag), 0);
    step();
    check("pause_exp", int'(expire_flag), 1);
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
